// File: rtl/cache_sram_arbiter.sv
// Single-port data-way arbiter: fixed priority rsp > rplc > lkup with a lookup
// starvation guard, a registered SRAM command port and read-return tracking.
module cache_sram_arbiter #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 512,
    parameter int WSTRB_W    = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               rsp_req,
    input  logic [ADDR_W-1:0]  rsp_addr,
    input  logic [DATA_W-1:0]  rsp_wdata,
    input  logic [WSTRB_W-1:0] rsp_wstrb,
    output logic               rsp_gnt,

    input  logic               rplc_req,
    input  logic [ADDR_W-1:0]  rplc_addr,
    input  logic [DATA_W-1:0]  rplc_wdata,
    output logic               rplc_gnt,

    input  logic               lkup_req,
    input  logic [ADDR_W-1:0]  lkup_addr,
    output logic               lkup_gnt,
    output logic               lkup_rvalid,
    output logic [DATA_W-1:0]  lkup_rdata,

    output logic               sram_cen,
    output logic               sram_wen,
    output logic [ADDR_W-1:0]  sram_addr,
    output logic [DATA_W-1:0]  sram_wdata,
    output logic [WSTRB_W-1:0] sram_wstrb,
    input  logic [DATA_W-1:0]  sram_rdata,

    output logic               arb_idle
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic               promote;
    logic [3:0]         starve_cnt_q, starve_cnt_d;
    logic               cen_q, cen_d;
    logic               wen_q, wen_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [WSTRB_W-1:0] wstrb_q, wstrb_d;
    logic               rd_pend_q, rd_pend_d;

    // A starved lookup overrides both writers for one cycle; the writer just holds.
    always_comb begin
        promote  = lkup_req && (starve_cnt_q == STARVE_LIM);
        rsp_gnt  = rsp_req && !promote;
        rplc_gnt = rplc_req && !rsp_req && !promote;
        lkup_gnt = lkup_req && (promote || (!rsp_req && !rplc_req));
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!lkup_req || lkup_gnt) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q < STARVE_LIM) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // Next SRAM command; address/data/strobe hold when nothing is granted.
    always_comb begin
        cen_d   = 1'b0;
        wen_d   = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        if (rsp_gnt) begin
            cen_d   = 1'b1;
            wen_d   = 1'b1;
            addr_d  = rsp_addr;
            wdata_d = rsp_wdata;
            wstrb_d = rsp_wstrb;
        end else if (rplc_gnt) begin
            cen_d   = 1'b1;
            wen_d   = 1'b1;
            addr_d  = rplc_addr;
            wdata_d = rplc_wdata;
            wstrb_d = '1;
        end else if (lkup_gnt) begin
            cen_d   = 1'b1;
            addr_d  = lkup_addr;
            wstrb_d = '0;
        end
    end

    assign rd_pend_d = cen_q && !wen_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
            cen_q        <= 1'b0;
            wen_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            rd_pend_q    <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            cen_q        <= cen_d;
            wen_q        <= wen_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            rd_pend_q    <= rd_pend_d;
        end
    end

    assign sram_cen    = cen_q;
    assign sram_wen    = wen_q;
    assign sram_addr   = addr_q;
    assign sram_wdata  = wdata_q;
    assign sram_wstrb  = wstrb_q;

    // SRAM read data is only meaningful the cycle after a read strobe.
    assign lkup_rvalid = rd_pend_q;
    assign lkup_rdata  = rd_pend_q ? sram_rdata : '0;

    assign arb_idle    = !rsp_req && !rplc_req && !lkup_req
                         && !(cen_q && !wen_q) && !rd_pend_q;

endmodule

// File: tb/tb_cache_sram_arbiter.sv
// Scoreboard bench for cache_sram_arbiter: directed requests push expected SRAM
// commands and read returns; a negedge monitor pops and compares them.
module tb_cache_sram_arbiter;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 512;
    localparam int WSTRB_W    = 64;
    localparam int STARVE_MAX = 4;

    typedef logic [DATA_W-1:0] line_t;
    typedef struct {
        logic               wen;
        logic [ADDR_W-1:0]  addr;
        line_t              wdata;
        logic [WSTRB_W-1:0] wstrb;
    } cmd_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               rsp_req = 1'b0;
    logic [ADDR_W-1:0]  rsp_addr = '0;
    line_t              rsp_wdata = '0;
    logic [WSTRB_W-1:0] rsp_wstrb = '0;
    logic               rsp_gnt;
    logic               rplc_req = 1'b0;
    logic [ADDR_W-1:0]  rplc_addr = '0;
    line_t              rplc_wdata = '0;
    logic               rplc_gnt;
    logic               lkup_req = 1'b0;
    logic [ADDR_W-1:0]  lkup_addr = '0;
    logic               lkup_gnt;
    logic               lkup_rvalid;
    line_t              lkup_rdata;
    logic               sram_cen;
    logic               sram_wen;
    logic [ADDR_W-1:0]  sram_addr;
    line_t              sram_wdata;
    logic [WSTRB_W-1:0] sram_wstrb;
    line_t              sram_rdata = '0;
    logic               arb_idle;

    logic               pre_we = 1'b0;
    logic [ADDR_W-1:0]  pre_addr = '0;
    line_t              pre_data = '0;
    line_t              mem [0:(1<<ADDR_W)-1];

    int    checks = 0;
    int    errors = 0;
    cmd_t  exp_cmd_q[$];
    line_t exp_rd_q[$];
    line_t last_wdata = '0;

    always #5 clk = ~clk;

    cache_sram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WSTRB_W(WSTRB_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .rsp_req(rsp_req), .rsp_addr(rsp_addr), .rsp_wdata(rsp_wdata),
        .rsp_wstrb(rsp_wstrb), .rsp_gnt(rsp_gnt),
        .rplc_req(rplc_req), .rplc_addr(rplc_addr), .rplc_wdata(rplc_wdata),
        .rplc_gnt(rplc_gnt),
        .lkup_req(lkup_req), .lkup_addr(lkup_addr), .lkup_gnt(lkup_gnt),
        .lkup_rvalid(lkup_rvalid), .lkup_rdata(lkup_rdata),
        .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_wstrb(sram_wstrb), .sram_rdata(sram_rdata),
        .arb_idle(arb_idle)
    );

    // Behavioural single-port SRAM with byte strobes and one-cycle read latency.
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (sram_cen && sram_wen) begin
            for (int b = 0; b < WSTRB_W; b++)
                if (sram_wstrb[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
        end else if (sram_cen) begin
            sram_rdata <= mem[sram_addr];
        end
    end

    always @(negedge clk) begin
        cmd_t e;
        if (!reset) begin
            if (sram_cen) begin
                checks++;
                if (exp_cmd_q.size() == 0) begin
                    errors++;
                    $display("FAIL sram_cmd: got access wen=%0b addr=%0h, required no access",
                             sram_wen, sram_addr);
                end else begin
                    e = exp_cmd_q.pop_front();
                    if (sram_wen !== e.wen || sram_addr !== e.addr ||
                        sram_wdata !== e.wdata || sram_wstrb !== e.wstrb) begin
                        errors++;
                        $display("FAIL sram_cmd: got wen=%0b addr=%0h wstrb=%0h wdata=%0h, required wen=%0b addr=%0h wstrb=%0h wdata=%0h",
                                 sram_wen, sram_addr, sram_wstrb, sram_wdata,
                                 e.wen, e.addr, e.wstrb, e.wdata);
                    end
                end
            end
            if (lkup_rvalid) begin
                checks++;
                if (exp_rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL lkup_rvalid: got rvalid=1, required no read return");
                end else begin
                    line_t r;
                    r = exp_rd_q.pop_front();
                    if (lkup_rdata !== r) begin
                        errors++;
                        $display("FAIL lkup_rdata: got %0h, required %0h", lkup_rdata, r);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, required %b", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input line_t act, input line_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input string nm, input logic [2:0] g, input logic idle);
        @(negedge clk);
        checks++;
        if ({rsp_gnt, rplc_gnt, lkup_gnt} !== g) begin
            errors++;
            $display("FAIL %s gnt: got rsp/rplc/lkup=%b, required %b",
                     nm, {rsp_gnt, rplc_gnt, lkup_gnt}, g);
        end
        chk1({nm, " idle"}, arb_idle, idle);
        step();
    endtask

    task automatic push_wr(input logic [ADDR_W-1:0] a, input line_t d,
                           input logic [WSTRB_W-1:0] s);
        cmd_t c;
        c.wen = 1'b1; c.addr = a; c.wdata = d; c.wstrb = s;
        exp_cmd_q.push_back(c);
        last_wdata = d;
    endtask

    task automatic push_rd(input logic [ADDR_W-1:0] a, input line_t rd);
        cmd_t c;
        c.wen = 1'b0; c.addr = a; c.wdata = last_wdata; c.wstrb = '0;
        exp_cmd_q.push_back(c);
        exp_rd_q.push_back(rd);
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input line_t d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        step();
        pre_we = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk1({nm, " cen"}, sram_cen, 1'b0);
        chk1({nm, " wen"}, sram_wen, 1'b0);
        chkw({nm, " addr"}, line_t'(sram_addr), '0);
        chkw({nm, " wdata"}, sram_wdata, '0);
        chkw({nm, " wstrb"}, line_t'(sram_wstrb), '0);
        chk1({nm, " rvalid"}, lkup_rvalid, 1'b0);
        chkw({nm, " rdata"}, lkup_rdata, '0);
        chk1({nm, " idle"}, arb_idle, 1'b1);
    endtask

    initial begin
        line_t w;
        step();
        step();
        @(negedge clk);
        chk_reset_outputs("rst");
        step();
        lkup_req = 1'b1; lkup_addr = 7'h05;
        @(negedge clk);
        chk1("rst lkup_gnt follows req", lkup_gnt, 1'b1);
        chk1("rst rsp_gnt", rsp_gnt, 1'b0);
        step();
        lkup_req = 1'b0;
        preload(7'h05, {64{8'hA5}});
        preload(7'h23, {64{8'hC3}});
        preload(7'h31, {64{8'h96}});
        preload(7'h10, {64{8'h3C}});
        reset = 1'b0;

        // Single lookup
        lkup_req = 1'b1; lkup_addr = 7'h05;
        push_rd(7'h05, {64{8'hA5}});
        cyc("t1 T", 3'b001, 1'b0);
        lkup_req = 1'b0;
        cyc("t1 T+1", 3'b000, 1'b0);
        cyc("t1 T+2", 3'b000, 1'b0);
        cyc("t1 T+3", 3'b000, 1'b1);

        // All three at once, each dropped after its grant
        rsp_req = 1'b1; rsp_addr = 7'h21; rsp_wdata = {16{32'hDEADBEEF}};
        rsp_wstrb = 64'h0F0F_0000_FFFF_0001;
        rplc_req = 1'b1; rplc_addr = 7'h22; rplc_wdata = {64{8'h77}};
        lkup_req = 1'b1; lkup_addr = 7'h23;
        push_wr(7'h21, {16{32'hDEADBEEF}}, 64'h0F0F_0000_FFFF_0001);
        push_wr(7'h22, {64{8'h77}}, '1);
        push_rd(7'h23, {64{8'hC3}});
        cyc("t2 T", 3'b100, 1'b0);
        rsp_req = 1'b0;
        cyc("t2 T+1", 3'b010, 1'b0);
        rplc_req = 1'b0;
        cyc("t2 T+2", 3'b001, 1'b0);
        lkup_req = 1'b0;
        cyc("t2 T+3", 3'b000, 1'b0);
        cyc("t2 T+4", 3'b000, 1'b0);
        cyc("t2 T+5", 3'b000, 1'b1);

        // Starvation guard, then a fresh request right after the promoted grant
        w = {8{64'h0123_4567_89AB_CDEF}};
        rsp_req = 1'b1; rsp_addr = 7'h30; rsp_wdata = w; rsp_wstrb = '1;
        lkup_req = 1'b1; lkup_addr = 7'h31;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < STARVE_MAX; i++) begin
                push_wr(7'h30, w, '1);
                cyc("t3 denied", 3'b100, 1'b0);
            end
            push_rd(7'h31, {64{8'h96}});
            cyc("t3 promoted", 3'b001, 1'b0);
        end
        rsp_req = 1'b0; lkup_req = 1'b0;
        cyc("t3 drain1", 3'b000, 1'b0);
        cyc("t3 drain2", 3'b000, 1'b0);
        cyc("t3 drain3", 3'b000, 1'b1);

        // Read/write ordering on one set
        lkup_req = 1'b1; lkup_addr = 7'h10;
        push_rd(7'h10, {64{8'h3C}});
        cyc("t4 T", 3'b001, 1'b0);
        lkup_req = 1'b0;
        rsp_req = 1'b1; rsp_addr = 7'h10; rsp_wdata = {64{8'h5A}}; rsp_wstrb = '1;
        push_wr(7'h10, {64{8'h5A}}, '1);
        cyc("t4 T+1", 3'b100, 1'b0);
        rsp_req = 1'b0;
        lkup_req = 1'b1; lkup_addr = 7'h10;
        push_rd(7'h10, {64{8'h5A}});
        cyc("t4 T+2", 3'b001, 1'b0);
        lkup_req = 1'b0;
        cyc("t4 T+3", 3'b000, 1'b0);
        cyc("t4 T+4", 3'b000, 1'b0);
        cyc("t4 T+5", 3'b000, 1'b1);

        // Strobe pass-through
        rsp_req = 1'b1; rsp_addr = 7'h40;
        rsp_wdata = {448'h0, 64'h1111_1111_1111_1111}; rsp_wstrb = 64'hFF;
        push_wr(7'h40, {448'h0, 64'h1111_1111_1111_1111}, 64'hFF);
        cyc("t5 T", 3'b100, 1'b0);
        rsp_req = 1'b0;
        cyc("t5 T+1", 3'b000, 1'b1);

        // Reset pulsed while a read is in flight
        lkup_req = 1'b1; lkup_addr = 7'h05;
        cyc("t6 T", 3'b001, 1'b0);
        lkup_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("t6 in reset");
        step();
        reset = 1'b0;
        last_wdata = '0;
        @(negedge clk);
        chk1("t6 no rvalid", lkup_rvalid, 1'b0);
        chk1("t6 idle", arb_idle, 1'b1);
        step();

        // Re-request after reset
        lkup_req = 1'b1; lkup_addr = 7'h05;
        push_rd(7'h05, {64{8'hA5}});
        cyc("t7 T", 3'b001, 1'b0);
        lkup_req = 1'b0;
        cyc("t7 T+1", 3'b000, 1'b0);
        cyc("t7 T+2", 3'b000, 1'b0);
        cyc("t7 T+3", 3'b000, 1'b1);

        chkw("end cmd queue drained", line_t'(exp_cmd_q.size()), '0);
        chkw("end read queue drained", line_t'(exp_rd_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule

// File: doc/cache_sram_arbiter.md
# cache_sram_arbiter

Single-port arbiter that shares one data-SRAM way between three cache requesters: the response stage's hit/refill write-merge, the replacement engine's line refill, and the lookup pipeline's line read. It picks one requester per cycle with fixed priority plus a starvation guard for lookups, registers the winning command onto the SRAM port, and tracks in-flight reads so it can return read data to the lookup pipeline. One instance sits in front of each data way.

## Interface
- ADDR_W, 7, SRAM set-index width
- DATA_W, 512, cache line width in bits
- WSTRB_W, 64, byte-strobe width (DATA_W/8)
- STARVE_MAX, 4, consecutive denied lookup cycles before lookup is promoted (legal 1..15)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- rsp_req  in  1  response write request; held until rsp_gnt
- rsp_addr  in  ADDR_W  response write set index
- rsp_wdata  in  DATA_W  response write data
- rsp_wstrb  in  WSTRB_W  response byte strobes
- rsp_gnt  out  1  response granted this cycle
- rplc_req  in  1  refill write request; held until rplc_gnt
- rplc_addr  in  ADDR_W  refill set index
- rplc_wdata  in  DATA_W  refill line
- rplc_gnt  out  1  refill granted this cycle
- lkup_req  in  1  lookup read request; held until lkup_gnt
- lkup_addr  in  ADDR_W  lookup set index
- lkup_gnt  out  1  lookup granted this cycle
- lkup_rvalid  out  1  lookup read data valid
- lkup_rdata  out  DATA_W  lookup read data
- sram_cen  out  1  SRAM chip enable
- sram_wen  out  1  SRAM write enable
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_wstrb  out  WSTRB_W  SRAM byte strobes
- sram_rdata  in  DATA_W  SRAM read data, valid one cycle after a read cen
- arb_idle  out  1  no request pending and no read in flight

## Operation
- Grants are combinational from current requests; at most one gnt high per cycle.
- Normal priority: rsp > rplc > lkup.
- Starvation counter starve_cnt (4 bits): increments when lkup_req & !lkup_gnt, saturates at STARVE_MAX; clears when lkup_gnt or !lkup_req.
- When starve_cnt == STARVE_MAX and lkup_req is high, lkup wins over rsp and rplc that cycle; the losing writer holds its request.
- Requesters keep addr/data stable while req is high and ungranted; dropping req without gnt is legal, and the request is then ignored.
- Winning command is registered onto the SRAM port:
  - rsp: cen=1, wen=1, addr/wdata/wstrb from rsp.
  - rplc: cen=1, wen=1, wdata=rplc_wdata, wstrb all ones.
  - lkup: cen=1, wen=0, addr=lkup_addr, wstrb=0, wdata holds its previous value.
- With no grant, cen and wen go to 0 and addr/wdata/wstrb hold their previous values.
- Read tracking: rd_pend is a register loaded with (sram_cen & !sram_wen). lkup_rvalid = rd_pend. lkup_rdata = sram_rdata when rd_pend, else 0.
- arb_idle = !rsp_req & !rplc_req & !lkup_req & !(sram_cen & !sram_wen) & !rd_pend.
- SRAM accesses execute in grant order, so a lookup granted before a write to the same set reads the old data, and one granted after reads the new data. No forwarding is done.

## Timing
- Reset values: all SRAM outputs 0, starve_cnt 0, rd_pend 0, lkup_rvalid 0, lkup_rdata 0, arb_idle 1. Gnts follow requests combinationally even during reset deassertion.
- Write latency: gnt in cycle T, SRAM write strobed at the edge ending T+1.
- Read latency: lkup_gnt in cycle T, sram_cen/wen=0 in T+1, lkup_rvalid with data in T+2.
- Throughput: one access per cycle, and back-to-back lookups give back-to-back rvalids.
- Reset asserted mid-operation clears the registered command and rd_pend immediately. A read in flight is dropped with no rvalid, and the requester must re-request.
- Simultaneous rsp+rplc+lkup with starve_cnt < STARVE_MAX: grant order is rsp, then rplc, then lkup on successive cycles if all requests hold.

## Test plan
- Single lookup: lkup_req at T, addr 0x05, SRAM returns 0xA5..A5 -> lkup_gnt at T; cen=1/wen=0/addr=0x05 at T+1; lkup_rvalid=1 with rdata 0xA5..A5 at T+2; arb_idle=1 at T+3.
- All three requests at T, each dropped after its grant -> rsp_gnt@T, rplc_gnt@T+1, lkup_gnt@T+2; SRAM shows rsp write@T+1, refill write (wstrb all ones)@T+2, read@T+3.
- Starvation with STARVE_MAX=4: rsp_req held high continuously and lkup_req high from T -> lkup denied T..T+3, lkup_gnt at T+4 with rsp_gnt=0; starve_cnt=0 at T+5.
- Read/write ordering: lkup@0x10 granted T, rsp write@0x10 granted T+1 -> rvalid at T+2 returns old data; a second lookup granted T+2 returns the written data at T+4.
- Reset during read: lkup_gnt at T, reset pulsed in T+1 -> no lkup_rvalid at T+2; all outputs at reset values.
- Strobe pass-through: rsp write with wstrb=0x00000000000000FF, wdata byte0..7=0x11 -> sram_wstrb/wdata match exactly at T+1, sram_wen=1.
